// File: rtl/trng_pkg.sv
// Shared constants for the TRNG byte packer: byte width, default FIFO depth,
// default repetition-count limit and the repetition-counter width.
package trng_pkg;
   localparam int BYTE_W         = 8;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int RCT_LIMIT_DEF  = 32;
   localparam int RCT_W          = 8;
endpackage

// File: rtl/trng_fifo.sv
// First-word fall-through byte FIFO; pointers carry one extra wrap bit so
// that full and empty can be told apart.
module trng_fifo
   import trng_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [BYTE_W-1:0] mem_d [DEPTH];
   logic              wr_en, rd_en;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];

   // When full, the write slot is the head slot; the head has already been
   // presented on dout this cycle, so overwriting it on a pop is safe.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (wr_en) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d                = wr_q + 1'b1;
      end
      if (rd_en) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
endmodule

// File: rtl/trng_byte_packer.sv
// Packs strobed TRNG bits MSB-first into bytes, buffers them in a FIFO and
// runs a repetition-count health test. Optional macro: TRNG_VN_DEBIAS_EN.
module trng_byte_packer
   import trng_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              random,
   input  logic              pulse,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic              health_fail
);
   logic [BYTE_W-1:0] sr_q, sr_d, push_byte;
   logic [2:0]        cnt_q, cnt_d;
   logic [RCT_W-1:0]  rct_q, rct_d;
   logic              prev_bit_q, prev_bit_d, prev_vld_q, prev_vld_d;
   logic              overflow_q, overflow_d, health_q, health_d;
   logic              bit_acc, feed, feed_bit, trip, push, pop, full, empty;

   assign bit_acc = pulse & en;

`ifdef TRNG_VN_DEBIAS_EN
   logic pair_have_q, pair_have_d, pair_a_q, pair_a_d;

   // Von Neumann pairing: 10 -> 1, 01 -> 0, equal pairs produce nothing.
   always_comb begin
      pair_have_d = pair_have_q;
      pair_a_d    = pair_a_q;
      feed        = 1'b0;
      feed_bit    = pair_a_q;
      if (!en) begin
         pair_have_d = 1'b0;
         pair_a_d    = 1'b0;
      end else if (bit_acc) begin
         if (!pair_have_q) begin
            pair_have_d = 1'b1;
            pair_a_d    = random;
         end else begin
            pair_have_d = 1'b0;
            feed        = pair_a_q ^ random;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pair_have_q <= 1'b0;
         pair_a_q    <= 1'b0;
      end else begin
         pair_have_q <= pair_have_d;
         pair_a_q    <= pair_a_d;
      end
   end
`else
   assign feed     = bit_acc;
   assign feed_bit = random;
`endif

   // Repetition-count test sees every raw accepted bit, before debiasing.
   always_comb begin
      rct_d      = rct_q;
      prev_bit_d = prev_bit_q;
      prev_vld_d = prev_vld_q;
      if (bit_acc) begin
         prev_vld_d = 1'b1;
         prev_bit_d = random;
         if (prev_vld_q && (prev_bit_q == random)) begin
            rct_d = (rct_q == {RCT_W{1'b1}}) ? rct_q : rct_q + 1'b1;
         end else begin
            rct_d = RCT_W'(1);
         end
      end
   end

   assign trip     = bit_acc && (rct_d == RCT_W'(RCT_LIMIT));
   assign health_d = health_q | trip;

   assign push_byte = {sr_q[BYTE_W-2:0], feed_bit};
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      push  = 1'b0;
      if (!en || health_d) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (feed) begin
         sr_d  = push_byte;
         cnt_d = cnt_q + 1'b1;
         push  = (cnt_q == 3'd7);
      end
   end

   assign overflow_d = overflow_q | (push & full & ~pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         rct_q      <= '0;
         prev_bit_q <= 1'b0;
         prev_vld_q <= 1'b0;
         overflow_q <= 1'b0;
         health_q   <= 1'b0;
      end else begin
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         rct_q      <= rct_d;
         prev_bit_q <= prev_bit_d;
         prev_vld_q <= prev_vld_d;
         overflow_q <= overflow_d;
         health_q   <= health_d;
      end
   end

   trng_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_byte),
      .pop   (pop),
      .dout  (out_data),
      .full  (full),
      .empty (empty)
   );

   assign overflow    = overflow_q;
   assign health_fail = health_q;
endmodule

// File: doc/trng_byte_packer.md
TRNG_BYTE_PACKER -- requirements
Module: trng_byte_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of byte entries buffered; it is a power of two, 2..16.
REQ-002 The block SHALL have parameter RCT_LIMIT, default 32, meaning the count of consecutive identical raw bits that trips the health test; range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every input is synchronous to it.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: collection enable.
REQ-006 The block SHALL have port random, input, 1 bit: raw entropy bit from the TRNG core.
REQ-007 The block SHALL have port pulse, input, 1 bit: single-cycle strobe marking random valid.
REQ-008 The block SHALL have port out_data, output, 8 bits: the head byte.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the byte.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, byte dropped because the FIFO was full.
REQ-012 The block SHALL have port health_fail, output, 1 bit: sticky flag, repetition-count test tripped.

Function
REQ-013 The block SHALL sample random only in cycles where pulse=1 and en=1; pulse cycles with en=0 are ignored.
REQ-014 Deasserting en SHALL clear the partial-byte bit counter and shift register on the next edge; FIFO contents are kept.
REQ-015 Each accepted bit SHALL shift in MSB-first (sr <= {sr[6:0], bit}); a 3-bit counter SHALL count bits, and on the 8th bit the completed byte SHALL be pushed into the FIFO on that same edge.
REQ-016 A pushed byte SHALL appear on out_data with out_valid=1 in the cycle after the 8th-bit edge when the FIFO was empty (first-word fall-through, 1-cycle latency).
REQ-017 A transfer SHALL occur on an edge where out_valid=1 and out_ready=1; out_data/out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 A push into a full FIFO with no simultaneous pop SHALL drop the new byte, keep the FIFO unchanged and set overflow.
REQ-019 A push into a full FIFO with a simultaneous pop SHALL be accepted, leaving the occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.
REQ-021 The repetition-count test SHALL run on raw accepted bits, before any debiasing.
REQ-022 The repetition counter SHALL reset to 1 when a bit differs from the previous one and increment, saturating, when it matches; health_fail SHALL set on the edge where the count reaches RCT_LIMIT.
REQ-023 While health_fail=1, no new bytes SHALL be pushed and the partial byte SHALL be discarded; bytes already in the FIFO remain drainable.
REQ-024 overflow and health_fail SHALL clear only on reset.

Reset
REQ-025 Reset SHALL asynchronously force out_valid=0, out_data=8'h00, overflow=0 and health_fail=0, with FIFO empty, bit counter=0, shift register=0, repetition count=0 and previous-bit flag invalid.
REQ-026 Reset asserted mid-byte or mid-FIFO SHALL discard all buffered data, and the first accepted bit after reset release SHALL begin a new byte.

Configuration
REQ-027 With macro TRNG_VN_DEBIAS_EN defined, the block SHALL pair accepted raw bits (first a, second b): 10 feeds 1 and 01 feeds 0 into the shift register, 00/11 are discarded, and clearing the shift register per REQ-014 also clears the pair-holding state.
REQ-028 Without TRNG_VN_DEBIAS_EN, every accepted raw bit SHALL feed the shift register directly, and no pair logic SHALL be synthesised.

Structure
REQ-029 A shared package trng_pkg SHALL hold the BYTE_W=8 constant, the default FIFO_DEPTH and RCT_LIMIT constants, and the repetition-counter width constant (8 bits).
REQ-030 The FIFO SHALL be a sub-module trng_fifo (push/pop/full/empty, parameter DEPTH), instantiated once.

Verification
REQ-031 Bench: en=1, 8 pulses with bits 1,0,1,1,0,0,1,0, out_ready=1 -> out_valid high one cycle after the 8th pulse with out_data=8'hB2.
REQ-032 Bench: out_ready=0, 5 bytes pushed with FIFO_DEPTH=4 -> overflow=1, then draining yields exactly the first 4 bytes in order.
REQ-033 Bench: FIFO full, with push and pop in the same cycle -> no overflow, occupancy stays 4, and byte order is preserved.
REQ-034 Bench: 32 consecutive random=1 pulses -> health_fail=1 on the 32nd pulse edge, and no further bytes are pushed.
REQ-035 Bench: TRNG_VN_DEBIAS_EN defined, raw pairs 10,01,11,00,10,10,01,01,10,01 -> byte 8'hB2.
REQ-036 Bench: reset asserted after 3 bits, then 8 bits 8'h5A -> out_data=8'h5A, with the pre-reset bits absent.
